timer_core: RTL and testbench
=============================

TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 SHALL provide parameter SEC_MAX, default 59, terminal value of seconds field.
REQ-002 SHALL provide parameter MIN_MAX, default 59, terminal value of minutes field.
REQ-003 SHALL provide parameter CW, default 6, field width; elaboration SHALL fail unless 2**CW > max(SEC_MAX, MIN_MAX) and both maxima >= 1.
REQ-004 clk  in  1  single master clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 tick_1hz  in  1  one-cycle count enable.
REQ-007 tick_adj  in  1  one-cycle adjust-rate enable (nominal 2 Hz).
REQ-008 pause_pulse  in  1  one-cycle debounced pause toggle request.
REQ-009 clear  in  1  one-cycle synchronous clear request.
REQ-010 adjust  in  1  level; 1 = adjust mode.
REQ-011 select  in  1  level; 1 = adjust seconds, 0 = adjust minutes.
REQ-012 down  in  1  level; 1 = count down, 0 = count up.
REQ-013 minutes  out  CW  registered minutes field.
REQ-014 seconds  out  CW  registered seconds field.
REQ-015 paused  out  1  high in PAUSED state.
REQ-016 expired  out  1  high in DONE state.
REQ-017 wrap  out  1  one-cycle pulse on up-count rollover MIN_MAX:SEC_MAX -> 0:0.

Function
REQ-018 SHALL implement states RUN, PAUSED, ADJ, DONE; all outputs registered, updated on the edge sampling the causing input (1-cycle latency).
REQ-019 Priority per edge SHALL be: rst_n low > clear > adjust > pause_pulse > tick_1hz.
REQ-020 clear SHALL set fields to 0:0, wrap=0, expired=0, state RUN, from any state; while adjust=1, state SHALL be ADJ with fields 0:0 instead.
REQ-021 RUN, tick_1hz, down=0: seconds+1; at SEC_MAX seconds->0 and minutes+1; at MIN_MAX:SEC_MAX both->0 and wrap=1 for that cycle.
REQ-022 RUN, tick_1hz, down=1: seconds-1; at 0 seconds->SEC_MAX with minutes-1; result 0:0 SHALL enter DONE same edge; tick at 0:0 SHALL enter DONE with fields unchanged.
REQ-023 Change of down SHALL take effect on the next tick_1hz; no field change on the toggle itself.
REQ-024 RUN + pause_pulse -> PAUSED; PAUSED + pause_pulse -> RUN; tick_1hz in the same cycle as pause_pulse SHALL be ignored; pause_pulse in ADJ or DONE SHALL be ignored.
REQ-025 adjust=1 in RUN, PAUSED or DONE -> ADJ; entry from DONE SHALL clear expired.
REQ-026 ADJ: tick_1hz ignored; tick_adj SHALL increment the selected field only, wrapping max->0, no carry into the other field, no wrap pulse.
REQ-027 adjust=0 in ADJ SHALL return to RUN if entered from RUN, else PAUSED; a tick_adj on that edge SHALL be ignored.
REQ-028 DONE: fields held, tick_1hz and tick_adj ignored; exit only via clear, adjust or reset.
REQ-029 Fields SHALL never exceed their maxima under any input sequence.

Reset
REQ-030 rst_n low at an edge SHALL force minutes=0, seconds=0, state RUN, paused=0, expired=0, wrap=0, return-state memory=RUN, overriding all other inputs, mid-adjust or mid-count.

Structure
REQ-031 State enum and default maxima SHALL live in shared package timer_pkg.
REQ-032 Each field SHALL be one instance of sub-module mod_counter (params MAX, CW; inc/dec enables, terminal flag out); timer_core holds FSM and chaining.
REQ-033 No derived clocks; all rate control via tick inputs.

Verification
REQ-034 Up: start 0:0, 3600 ticks -> back to 0:0, wrap exactly once, on the 3600th tick.
REQ-035 Down: adjust to 0:02, release adjust (return RUN), down=1, 2 ticks -> 0:01, then 0:00 with expired=1; further ticks hold 0:00.
REQ-036 Pause: RUN at 0:10, pause_pulse coincident with tick -> paused=1, 0:10; 5 ticks -> 0:10; pause_pulse -> RUN, next tick -> 0:11.
REQ-037 Adjust: select=1, seconds=59, tick_adj -> seconds=0, minutes unchanged; select=0, minutes=59, tick_adj -> minutes=0.
REQ-038 Reset/clear: rst_n low during ADJ at 12:34 -> next edge 0:0, RUN, all flags 0; clear with adjust=1 -> ADJ at 0:0.
REQ-039 Params SEC_MAX=9, MIN_MAX=5, CW=4: 60 up ticks -> 0:0 with one wrap.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default field limits and a small helper
package timer_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_ADJ, ST_DONE} state_t;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;
  localparam int CW_DEF = 6;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/timer_core_if.sv
// timer_core_if: control pulses/levels into the timer and registered time/status back out
interface timer_core_if import timer_pkg::*; #(parameter int CW = CW_DEF) ();
  logic          tick_1hz;
  logic          tick_adj;
  logic          pause_pulse;
  logic          clear;
  logic          adjust;
  logic          select;
  logic          down;
  logic [CW-1:0] minutes;
  logic [CW-1:0] seconds;
  logic          paused;
  logic          expired;
  logic          wrap;
  modport master (
    output tick_1hz, tick_adj, pause_pulse, clear, adjust, select, down,
    input  minutes, seconds, paused, expired, wrap
  );
  modport slave (
    input  tick_1hz, tick_adj, pause_pulse, clear, adjust, select, down,
    output minutes, seconds, paused, expired, wrap
  );
endinterface

// File: rtl/timer_core_mod_counter.sv
// mod_counter: modulo-(MAX+1) up/down field with terminal flags for chaining
module mod_counter import timer_pkg::*; #(
  parameter int MAX = SEC_MAX_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          at_max,
  output logic          at_zero
);
  localparam logic [CW-1:0] MAXV = CW'(MAX);
  logic [CW-1:0] cnt_d, cnt_q;
  assign at_max  = cnt_q >= MAXV;
  assign at_zero = cnt_q == '0;
  assign cnt     = cnt_q;
  // next count: clear wins, then increment (wrap to 0), then decrement (wrap to MAX)
  always_comb begin
    cnt_d = clr ? '0 :
            inc ? (at_max ? '0 : cnt_q + 1'b1) :
            dec ? (at_zero ? MAXV : cnt_q - 1'b1) : cnt_q;
  end
  // field register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/timer_core.sv
// timer_core: mm:ss run/pause/adjust/countdown timer built from two chained mod_counters
module timer_core import timer_pkg::*; #(
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  timer_core_if.slave bus
);
  if (!((2 ** CW) > max2(SEC_MAX, MIN_MAX) && SEC_MAX >= 1 && MIN_MAX >= 1)) begin : g_bad_params
    $error("timer_core: CW too narrow for the field maxima, or a maximum below 1");
  end
  state_t        state_d, state_q, ret_d, ret_q;
  logic          wrap_d, wrap_q;
  logic          clr, sec_inc, sec_dec, min_inc, min_dec;
  logic [CW-1:0] sec, mins;
  logic          sec_max, sec_zero, min_max, min_zero;
  mod_counter #(.MAX(SEC_MAX), .CW(CW)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(sec_inc), .dec(sec_dec),
    .cnt(sec), .at_max(sec_max), .at_zero(sec_zero)
  );
  mod_counter #(.MAX(MIN_MAX), .CW(CW)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(min_inc), .dec(min_dec),
    .cnt(mins), .at_max(min_max), .at_zero(min_zero)
  );
  // next state and field enables, resolved as clear > adjust > pause > tick
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    wrap_d  = 1'b0;
    clr     = 1'b0;
    sec_inc = 1'b0;
    sec_dec = 1'b0;
    min_inc = 1'b0;
    min_dec = 1'b0;
    if (bus.clear) begin
      clr     = 1'b1;
      state_d = bus.adjust ? ST_ADJ : ST_RUN;
      ret_d   = ST_RUN;
    end else if (bus.adjust) begin
      if (state_q != ST_ADJ) begin
        state_d = ST_ADJ;
        ret_d   = state_q == ST_RUN ? ST_RUN : ST_PAUSED;
      end else if (bus.tick_adj) begin
        sec_inc = bus.select;
        min_inc = !bus.select;
      end
    end else if (state_q == ST_ADJ) begin
      state_d = ret_q;
    end else if (state_q == ST_RUN || state_q == ST_PAUSED) begin
      if (bus.pause_pulse) begin
        state_d = state_q == ST_RUN ? ST_PAUSED : ST_RUN;
      end else if (bus.tick_1hz && state_q == ST_RUN) begin
        if (!bus.down) begin
          sec_inc = 1'b1;
          min_inc = sec_max;
          wrap_d  = sec_max && min_max;
        end else if (sec_zero && min_zero) begin
          state_d = ST_DONE;
        end else begin
          sec_dec = 1'b1;
          min_dec = sec_zero;
          state_d = (min_zero && sec == CW'(1)) ? ST_DONE : ST_RUN;
        end
      end
    end
  end
  // state, return-state memory and wrap pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wrap_q  <= wrap_d;
    end
  end
  assign bus.minutes = mins;
  assign bus.seconds = sec;
  assign bus.paused  = state_q == ST_PAUSED;
  assign bus.expired = state_q == ST_DONE;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_timer_core.sv
// tb_timer_core: vector table, directed corner sequences and random run against a time-total model
module tb_timer_core;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  timer_core_if #(.CW(6)) i_a ();
  timer_core_if #(.CW(4)) i_b ();
  timer_core dut_a (.clk(clk), .rst_n(rst_n), .bus(i_a));
  timer_core #(.SEC_MAX(9), .MIN_MAX(5), .CW(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(i_b));

  int n_cmp = 0;
  int n_bad = 0;
  int tot = 0;
  bit m_paused, m_expired, m_adj, m_ret_p, m_wrap;

  typedef struct {
    bit rs, cl, ad, se, dn, pp, t1, ta;
    int em, es;
    bit ep, ex, ew;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model: the time is one integer of elapsed seconds; modes are plain flags
  task automatic mdl(input bit rs, cl, ad, se, dn, pp, t1, ta);
    int s, m;
    m_wrap = 0;
    if (!rs) begin
      tot = 0; m_paused = 0; m_expired = 0; m_adj = 0; m_ret_p = 0;
    end else if (cl) begin
      tot = 0; m_paused = 0; m_expired = 0; m_adj = ad; m_ret_p = 0;
    end else if (ad) begin
      if (!m_adj) begin
        m_ret_p = m_paused || m_expired; m_adj = 1; m_paused = 0; m_expired = 0;
      end else if (ta) begin
        s = tot % 60; m = tot / 60;
        if (se) s = (s + 1) % 60; else m = (m + 1) % 60;
        tot = m * 60 + s;
      end
    end else if (m_adj) begin
      m_adj = 0; m_paused = m_ret_p;
    end else if (!m_expired) begin
      if (pp) m_paused = !m_paused;
      else if (t1 && !m_paused) begin
        if (!dn) begin
          tot = (tot + 1) % 3600; m_wrap = (tot == 0);
        end else begin
          if (tot > 0) tot--;
          m_expired = (tot == 0);
        end
      end
    end
  endtask

  task automatic cyc(input bit rs, cl, ad, se, dn, pp, t1, ta);
    rst_n = rs; i_a.clear = cl; i_a.adjust = ad; i_a.select = se; i_a.down = dn;
    i_a.pause_pulse = pp; i_a.tick_1hz = t1; i_a.tick_adj = ta;
    @(posedge clk);
    #1;
    mdl(rs, cl, ad, se, dn, pp, t1, ta);
    chk("minutes", int'(i_a.minutes), tot / 60);
    chk("seconds", int'(i_a.seconds), tot % 60);
    chk("paused", int'(i_a.paused), int'(m_paused));
    chk("expired", int'(i_a.expired), int'(m_expired));
    chk("wrap", int'(i_a.wrap), int'(m_wrap));
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int wraps, wrap_at;
    bit ad, se, dn;
    rst_n = 0;
    i_b.clear = 0; i_b.adjust = 0; i_b.select = 0; i_b.down = 0;
    i_b.pause_pulse = 0; i_b.tick_1hz = 0; i_b.tick_adj = 0;
    tbl[0]  = '{0,0,0,0,0,0,0,0, 0,0, 0,0,0};
    tbl[1]  = '{1,0,0,0,0,0,1,0, 0,1, 0,0,0};
    tbl[2]  = '{1,0,0,0,0,0,1,0, 0,2, 0,0,0};
    tbl[3]  = '{1,0,0,0,0,1,1,0, 0,2, 1,0,0};
    tbl[4]  = '{1,0,0,0,0,0,1,0, 0,2, 1,0,0};
    tbl[5]  = '{1,0,0,0,0,1,0,0, 0,2, 0,0,0};
    tbl[6]  = '{1,0,0,0,1,0,0,0, 0,2, 0,0,0};
    tbl[7]  = '{1,0,0,0,1,0,1,0, 0,1, 0,0,0};
    tbl[8]  = '{1,0,0,0,1,0,1,0, 0,0, 0,1,0};
    tbl[9]  = '{1,0,0,0,1,0,1,0, 0,0, 0,1,0};
    tbl[10] = '{1,0,0,0,1,1,0,0, 0,0, 0,1,0};
    tbl[11] = '{1,0,1,1,1,0,1,0, 0,0, 0,0,0};
    tbl[12] = '{1,0,1,1,1,0,1,1, 0,1, 0,0,0};
    tbl[13] = '{1,0,1,0,1,0,0,1, 1,1, 0,0,0};
    tbl[14] = '{1,0,0,0,1,0,0,1, 1,1, 1,0,0};
    tbl[15] = '{1,0,0,0,0,1,0,0, 1,1, 0,0,0};
    tbl[16] = '{1,0,0,0,0,0,1,0, 1,2, 0,0,0};
    tbl[17] = '{1,1,0,0,0,0,1,0, 0,0, 0,0,0};
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rs, tbl[i].cl, tbl[i].ad, tbl[i].se, tbl[i].dn, tbl[i].pp, tbl[i].t1, tbl[i].ta);
      chk($sformatf("tbl%0d_min", i), int'(i_a.minutes), tbl[i].em);
      chk($sformatf("tbl%0d_sec", i), int'(i_a.seconds), tbl[i].es);
      chk($sformatf("tbl%0d_paused", i), int'(i_a.paused), int'(tbl[i].ep));
      chk($sformatf("tbl%0d_expired", i), int'(i_a.expired), int'(tbl[i].ex));
      chk($sformatf("tbl%0d_wrap", i), int'(i_a.wrap), int'(tbl[i].ew));
    end
    // full up-count cycle: one wrap, on the 3600th tick
    wraps = 0; wrap_at = -1;
    for (int i = 0; i < 3600; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      if (i_a.wrap) begin wraps++; wrap_at = i; end
    end
    chk("up_wrap_count", wraps, 1);
    chk("up_wrap_tick", wrap_at, 3599);
    chk("up_end_sec", int'(i_a.seconds), 0);
    // countdown to expiry from 0:02 set in adjust mode
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0, 1);
    cyc(1, 0, 1, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    chk("dn_ret_run", int'(i_a.paused), 0);
    cyc(1, 0, 0, 0, 1, 0, 1, 0);
    chk("dn_sec1", int'(i_a.seconds), 1);
    cyc(1, 0, 0, 0, 1, 0, 1, 0);
    chk("dn_sec0", int'(i_a.seconds), 0);
    chk("dn_expired", int'(i_a.expired), 1);
    cyc(1, 0, 0, 0, 1, 0, 1, 0);
    chk("dn_hold", int'(i_a.seconds), 0);
    // pause coincident with tick
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 0);
    chk("pz_paused", int'(i_a.paused), 1);
    chk("pz_sec", int'(i_a.seconds), 10);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("pz_hold", int'(i_a.seconds), 10);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("pz_resume", int'(i_a.seconds), 11);
    // adjust wrap of each field without carry
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 59; i++) cyc(1, 0, 1, 1, 0, 0, 0, 1);
    chk("adj_sec59", int'(i_a.seconds), 59);
    cyc(1, 0, 1, 1, 0, 0, 0, 1);
    chk("adj_sec_wrap", int'(i_a.seconds), 0);
    chk("adj_min_kept", int'(i_a.minutes), 3);
    for (int i = 0; i < 56; i++) cyc(1, 0, 1, 0, 0, 0, 0, 1);
    chk("adj_min59", int'(i_a.minutes), 59);
    cyc(1, 0, 1, 0, 0, 0, 0, 1);
    chk("adj_min_wrap", int'(i_a.minutes), 0);
    chk("adj_no_wrap", int'(i_a.wrap), 0);
    // reset in the middle of adjust at 12:34
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 34; i++) cyc(1, 0, 1, 1, 0, 0, 0, 1);
    chk("rst_pre_min", int'(i_a.minutes), 12);
    cyc(0, 0, 1, 1, 0, 0, 1, 1);
    chk("rst_min", int'(i_a.minutes), 0);
    chk("rst_sec", int'(i_a.seconds), 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_runs", int'(i_a.seconds), 1);
    cyc(1, 1, 1, 1, 0, 0, 1, 1);
    chk("clr_adj_sec", int'(i_a.seconds), 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 0);
    chk("clr_adj_tick_ignored", int'(i_a.seconds), 0);
    cyc(1, 0, 1, 1, 0, 0, 0, 1);
    chk("clr_adj_is_adj", int'(i_a.seconds), 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // small-parameter instance: 60 up ticks for a 6:10 range
    i_b.tick_1hz = 1;
    wraps = 0; wrap_at = -1;
    for (int i = 0; i < 60; i++) begin
      idle();
      if (i_b.wrap) begin wraps++; wrap_at = i; end
      if (i == 9) chk("b_carry_min", int'(i_b.minutes), 1);
      if (i == 58) chk("b_top_sec", int'(i_b.seconds), 9);
    end
    i_b.tick_1hz = 0;
    chk("b_wrap_count", wraps, 1);
    chk("b_wrap_tick", wrap_at, 59);
    chk("b_end_min", int'(i_b.minutes), 0);
    chk("b_end_sec", int'(i_b.seconds), 0);
    // random stimulus against the model
    ad = 0; se = 0; dn = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) ad = !ad;
      if ($urandom_range(0, 19) == 0) se = !se;
      if ($urandom_range(0, 19) == 0) dn = !dn;
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 59) == 0, ad, se, dn,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
